// File: rtl/wb_bram_bridge.sv
// Wishbone B4 classic slave bridging QSPI Wishbone master requests onto a single-port BRAM.
// Define WB_BRAM_OUTREG_EN when the RAM is built with a registered output (DO_REG=1).
module wb_bram_bridge #(
    parameter int          AW        = 9,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic          wbs_we_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [3:0]    wbs_sel_i,
    output logic [31:0]   wbs_dat_o,
    output logic          wbs_ack_o,
    output logic          wbs_err_o,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_we,
    output logic [31:0]   mem_di,
    input  logic [31:0]   mem_do,
    output logic [7:0]    err_cnt,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
`ifdef WB_BRAM_OUTREG_EN
        RD_PIPE,
`endif
        RD_CAP,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   req;
    logic   hit;
    logic   ack_nxt;
    logic   err_nxt;
    logic   cap;
    logic   unused_adr;

    // rst_n gates the accept so the RAM is never strobed while reset is held
    assign req        = (state == IDLE) && wbs_cyc_i && wbs_stb_i && rst_n;
    assign hit        = (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign mem_en     = req && hit;
    assign mem_we     = (mem_en && wbs_we_i) ? wbs_sel_i : 4'b0000;
    assign mem_addr   = wbs_adr_i[AW+1:2];
    assign mem_di     = wbs_dat_i;
    assign busy       = (state != IDLE);
    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        cap       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (!hit) begin
                        state_nxt = RESP;
                        err_nxt   = 1'b1;
                    end else if (wbs_we_i) begin
                        state_nxt = RESP;
                        ack_nxt   = 1'b1;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else begin
`ifdef WB_BRAM_OUTREG_EN
                    state_nxt = RD_PIPE;
`else
                    state_nxt = RD_CAP;
`endif
                end
            end
`ifdef WB_BRAM_OUTREG_EN
            RD_PIPE: begin
                state_nxt = wbs_cyc_i ? RD_CAP : IDLE;
            end
`endif
            RD_CAP: begin
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RESP;
                    ack_nxt   = 1'b1;
                    cap       = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            err_cnt   <= 8'h00;
        end else begin
            state     <= state_nxt;
            wbs_ack_o <= ack_nxt;
            wbs_err_o <= err_nxt;
            if (cap) begin
                wbs_dat_o <= mem_do;
            end
            if (err_nxt && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'h01;
            end
        end
    end

endmodule
